// File: rtl/sev_seg_pkg.sv
// Shared constants and types for the seven-segment readback block:
// segment code map, default geometry and the dwell-tracking state enum.
package sev_seg_pkg;

  localparam int unsigned DEFAULT_DIGITS        = 4;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 8;
  localparam int unsigned SEG_W                 = 7;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

  localparam logic [15:0][SEG_W-1:0] SEG_CODES = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    CAPTURED = 2'd2
  } state_t;

endpackage

// File: rtl/sev_seg_encoder.sv
// Combinational map from an active-low {g..a} pattern back to a hex nibble;
// hit_c is low when the pattern is not one of the sixteen hex glyphs.
module sev_seg_encoder
  import sev_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       nibble_c,
  output logic             hit_c
);

  always_comb begin
    nibble_c = '0;
    hit_c    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODES[i]) begin
        nibble_c = 4'(i);
        hit_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sev_seg_reader.sv
// Reconstructs the hex word shown on a multiplexed active-low 7-seg bus.
// Define SEV_SEG_READER_DP_EN to track and publish decimal points in dp_out.
module sev_seg_reader
  import sev_seg_pkg::*;
#(
  parameter int unsigned DIGITS        = DEFAULT_DIGITS,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [7:0]            sev_seg_leds,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp_out,
  output logic                  valid,
  output logic                  err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SMP_W = DIGITS + 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]               seg_in;
  logic [SMP_W-1:0]         sample;
  logic [SMP_W-1:0]         smp_q;
  logic                     one_hot;
  logic                     same;
  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [DIGITS-1:0]        seen_q;
  logic [DIGITS-1:0]        seen_nxt;
  logic [DIGITS-1:0]        digit_sel;
  logic [DIGITS-1:0][3:0]   slot_q;
  logic [DIGITS-1:0][3:0]   slot_nxt;
  logic [3:0]               nib_c;
  logic                     hit_c;
  logic                     cap;
  logic                     wr;
  logic                     complete;

`ifdef SEV_SEG_READER_DP_EN
  assign seg_in = sev_seg_leds;
`else
  // Decimal point is masked so dp toggles never restart a dwell
  logic unused_dp;
  assign unused_dp = sev_seg_leds[0];
  assign seg_in    = {sev_seg_leds[7:1], 1'b0};
`endif

  assign sample = {an_n, seg_in};
  assign same   = (sample == smp_q);

  always_comb begin
    int unsigned zeros;
    zeros = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_n[i]) zeros++;
    end
    one_hot = (zeros == 1);
  end

  sev_seg_encoder u_enc (
    .seg      (smp_q[7:1]),
    .nibble_c (nib_c),
    .hit_c    (hit_c)
  );

  // The registered sample is what gets decoded; it equals the live one on a capture edge
  assign digit_sel = ~smp_q[SMP_W-1:8];
  assign cap       = !clear && (state_q == TRACK) && same && (cnt_q == CNT_LAST);
  assign wr        = cap && hit_c;
  assign complete  = wr && (&seen_nxt);

  always_comb begin
    slot_nxt = slot_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_sel[i]) slot_nxt[i] = nib_c;
    end
    seen_nxt = seen_q | digit_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      smp_q   <= '0;
      seen_q  <= '0;
      slot_q  <= '0;
      value   <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= complete;
      err   <= cap && !hit_c;

      if (wr)       slot_q <= slot_nxt;
      if (complete) value  <= slot_nxt;

      if (clear || complete) seen_q <= '0;
      else if (wr)           seen_q <= seen_nxt;

      // Dwell tracking: CAPTURED simply holds while the sample is unchanged
      if (clear || !one_hot) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (state_q == IDLE || !same) begin
        state_q <= TRACK;
        cnt_q   <= CNT_W'(1);
        smp_q   <= sample;
      end else if (state_q == TRACK) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_q <= CAPTURED;
      end
    end
  end

`ifdef SEV_SEG_READER_DP_EN
  logic [DIGITS-1:0] dp_q;
  logic [DIGITS-1:0] dp_nxt;

  always_comb begin
    dp_nxt = dp_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_sel[i]) dp_nxt[i] = ~smp_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q   <= '0;
      dp_out <= '0;
    end else begin
      if (wr)       dp_q   <= dp_nxt;
      if (complete) dp_out <= dp_nxt;
    end
  end
`else
  assign dp_out = '0;
`endif

endmodule

// File: tb/tb_sev_seg_reader.sv
// Self-checking bench for sev_seg_reader: directed scenarios plus a randomized
// run compared cycle by cycle against a run-length reference model.
module tb_sev_seg_reader;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SC     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an_n = 4'hF;
  logic [7:0]  sev_seg_leds = 8'hFF;
  logic        clear = 1'b0;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic        valid;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] codes [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model state: run length of identical one-hot samples
  logic [11:0] m_last;
  int          m_run;
  int          m_slot [4];
  logic [3:0]  m_dps;
  logic [3:0]  m_seen;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic        m_valid;
  logic        m_err;

  sev_seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .an_n         (an_n),
    .sev_seg_leds (sev_seg_leds),
    .clear        (clear),
    .value        (value),
    .dp_out       (dp_out),
    .valid        (valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  function automatic logic [7:0] seg_of(input int n, input bit dp_lit);
    logic [6:0] c;
    c = codes[n];
    return {c, ~dp_lit};
  endfunction

  task automatic model_reset();
    m_last = '0; m_run = 0; m_seen = '0; m_dps = '0;
    m_value = '0; m_dp = '0; m_valid = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 4; k++) m_slot[k] = 0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [7:0] s, input logic c);
    logic [7:0]  sm;
    logic [11:0] smp;
    int zeros, d, found;
    m_valid = 1'b0;
    m_err   = 1'b0;
    sm = s;
`ifndef SEV_SEG_READER_DP_EN
    sm[0] = 1'b0;
`endif
    smp = {a, sm};
    zeros = 0; d = 0;
    for (int k = 0; k < 4; k++) if (!a[k]) begin zeros++; d = k; end
    if (c) begin
      m_run = 0; m_seen = '0;
    end else if (zeros != 1) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && smp == m_last) m_run++;
      else begin m_run = 1; m_last = smp; end
      if (m_run == SC) begin
        found = -1;
        for (int k = 0; k < 16; k++) if (codes[k] == s[7:1]) found = k;
        if (found >= 0) begin
          m_slot[d] = found;
          m_dps[d]  = ~s[0];
          m_seen[d] = 1'b1;
          if (m_seen == 4'hF) begin
            for (int k = 0; k < 4; k++) m_value[4*k +: 4] = 4'(m_slot[k]);
`ifdef SEV_SEG_READER_DP_EN
            m_dp = m_dps;
`endif
            m_valid = 1'b1;
            m_seen  = '0;
          end
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic [3:0] a, input logic [7:0] s, input logic c);
    an_n = a; sev_seg_leds = s; clear = c;
    @(posedge clk);
    model_step(a, s, c);
    #1;
  endtask

  task automatic dwell(input int d, input logic [7:0] s, input int n, output int nv, output int ne);
    nv = 0; ne = 0;
    for (int i = 0; i < n; i++) begin
      cyc(an_of(d), s, 1'b0);
      nv += int'(valid);
      ne += int'(err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; an_n = 4'hF; sev_seg_leds = 8'hFF; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (value !== 16'h0) begin n_fail++; $display("FAIL reset_value: got %h want 0000", value); end
    n_tests++; if (dp_out !== 4'h0) begin n_fail++; $display("FAIL reset_dp: got %b want 0000", dp_out); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'hF, 8'hFF, 1'b0);
    n_tests++; if (valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got valid=%b err=%b want 0 0", valid, err);
    end
  endtask

  task automatic test_basic_word();
    int nv, ne, tv;
    tv = 0;
    for (int d = 0; d < 3; d++) begin dwell(d, seg_of(d + 1, 0), 8, nv, ne); tv += nv; end
    dwell(3, seg_of(4, 0), 7, nv, ne); tv += nv;
    n_tests++; if (tv != 0) begin n_fail++; $display("FAIL basic_early_valid: got %0d pulses want 0", tv); end
    cyc(an_of(3), seg_of(4, 0), 1'b0);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_edge32: got %b want 1", valid); end
    n_tests++; if (value !== 16'h4321) begin n_fail++; $display("FAIL basic_value: got %h want 4321", value); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
    cyc(an_of(3), seg_of(4, 0), 1'b0);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: got %b want 0", valid); end
    n_tests++; if (dp_out !== 4'h0) begin n_fail++; $display("FAIL basic_dp: got %b want 0000", dp_out); end
  endtask

  task automatic test_short_dwell();
    int nv, ne, tv;
    tv = 0;
    dwell(2, seg_of(5, 0), 7, nv, ne); tv += nv;
    dwell(0, seg_of(6, 0), 8, nv, ne); tv += nv;
    dwell(1, seg_of(7, 0), 8, nv, ne); tv += nv;
    dwell(3, seg_of(9, 0), 8, nv, ne); tv += nv;
    n_tests++; if (tv != 0) begin n_fail++; $display("FAIL short_no_valid: got %0d pulses want 0", tv); end
    n_tests++; if (value !== 16'h4321) begin n_fail++; $display("FAIL short_value_held: got %h want 4321", value); end
    dwell(2, seg_of(5, 0), 8, nv, ne);
    n_tests++; if (nv != 1) begin n_fail++; $display("FAIL short_complete: got %0d pulses want 1", nv); end
    n_tests++; if (value !== 16'h9576) begin n_fail++; $display("FAIL short_value: got %h want 9576", value); end
  endtask

  task automatic test_bad_code();
    int nv, ne;
    logic [7:0] bad;
    bad = {7'b1010101, 1'b1};
    dwell(1, bad, 7, nv, ne);
    n_tests++; if (ne != 0) begin n_fail++; $display("FAIL bad_early_err: got %0d want 0", ne); end
    cyc(an_of(1), bad, 1'b0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err_edge8: got %b want 1", err); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bad_valid: got %b want 0", valid); end
    dwell(1, bad, 4, nv, ne);
    n_tests++; if (ne != 0 || nv != 0) begin
      n_fail++; $display("FAIL bad_repeat: got err=%0d valid=%0d want 0 0", ne, nv);
    end
    n_tests++; if (value !== 16'h9576) begin n_fail++; $display("FAIL bad_value_held: got %h want 9576", value); end
  endtask

  task automatic test_glitch();
    int nv, ne, tv;
    tv = 0;
    dwell(1, seg_of(11, 0), 8, nv, ne); tv += nv;
    dwell(2, seg_of(12, 0), 8, nv, ne); tv += nv;
    dwell(3, seg_of(13, 0), 8, nv, ne); tv += nv;
    dwell(0, seg_of(10, 0), 4, nv, ne); tv += nv;
    for (int i = 0; i < 3; i++) begin cyc(4'b1100, seg_of(10, 0), 1'b0); tv += int'(valid); end
    dwell(0, seg_of(10, 0), 7, nv, ne); tv += nv;
    n_tests++; if (tv != 0) begin n_fail++; $display("FAIL glitch_no_restart: got %0d pulses want 0", tv); end
    cyc(an_of(0), seg_of(10, 0), 1'b0);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL glitch_capture: got %b want 1", valid); end
    n_tests++; if (value !== 16'hDCBA) begin n_fail++; $display("FAIL glitch_value: got %h want dcba", value); end
  endtask

  task automatic test_clear();
    int nv, ne;
    for (int d = 0; d < 3; d++) dwell(d, seg_of(1, 0), 8, nv, ne);
    dwell(3, seg_of(1, 0), 7, nv, ne);
    cyc(an_of(3), seg_of(1, 0), 1'b1);
    n_tests++; if (valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL clear_wins: got valid=%b err=%b want 0 0", valid, err);
    end
    n_tests++; if (value !== 16'hDCBA) begin n_fail++; $display("FAIL clear_value_held: got %h want dcba", value); end
    dwell(3, seg_of(1, 0), 8, nv, ne);
    n_tests++; if (nv != 0) begin n_fail++; $display("FAIL clear_discards: got %0d pulses want 0", nv); end
  endtask

  task automatic test_reset_mid();
    int nv, ne, tv;
    dwell(0, seg_of(5, 0), 8, nv, ne);
    dwell(1, seg_of(5, 0), 8, nv, ne);
    dwell(2, seg_of(5, 0), 4, nv, ne);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (value !== 16'h0 || dp_out !== 4'h0 || valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got value=%h dp=%b valid=%b err=%b want all 0", value, dp_out, valid, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tv = 0;
    dwell(2, seg_of(6, 0), 8, nv, ne); tv += nv;
    dwell(3, seg_of(7, 0), 8, nv, ne); tv += nv;
    dwell(0, seg_of(8, 0), 8, nv, ne); tv += nv;
    n_tests++; if (tv != 0) begin n_fail++; $display("FAIL reset_seen_cleared: got %0d pulses want 0", tv); end
    dwell(1, seg_of(9, 0), 8, nv, ne);
    n_tests++; if (nv != 1 || value !== 16'h7698) begin
      n_fail++; $display("FAIL reset_next_word: got %0d pulses value=%h want 1 7698", nv, value);
    end
  endtask

  task automatic test_all_codes();
    int nv, ne, tv;
    logic [15:0] exp;
    for (int w = 0; w < 4; w++) begin
      tv = 0;
      for (int d = 0; d < 4; d++) begin
        dwell(d, seg_of(4 * w + d, 0), 8, nv, ne); tv += nv;
        exp[4*d +: 4] = 4'(4 * w + d);
      end
      n_tests++; if (tv != 1 || value !== exp) begin
        n_fail++; $display("FAIL codes_word%0d: got %0d pulses value=%h want 1 %h", w, tv, value, exp);
      end
    end
  endtask

  task automatic test_dp();
    int nv, ne, first;
    logic [3:0] exp_dp;
    logic [3:0] exp_dp2;
    int exp_first;
`ifdef SEV_SEG_READER_DP_EN
    exp_dp = 4'b1000; exp_dp2 = 4'b0001; exp_first = 0;
`else
    exp_dp = 4'b0000; exp_dp2 = 4'b0000; exp_first = 1;
`endif
    for (int d = 0; d < 3; d++) dwell(d, seg_of(d + 5, 0), 8, nv, ne);
    dwell(3, 8'b00000000, 8, nv, ne);
    n_tests++; if (nv != 1 || value[15:12] !== 4'h8) begin
      n_fail++; $display("FAIL dp_digit3: got %0d pulses nibble=%h want 1 8", nv, value[15:12]);
    end
    n_tests++; if (dp_out !== exp_dp) begin n_fail++; $display("FAIL dp_out_lit: got %b want %b", dp_out, exp_dp); end
    for (int d = 1; d < 4; d++) dwell(d, seg_of(d, 0), 8, nv, ne);
    dwell(0, seg_of(2, 0), 4, nv, ne); first = nv;
    dwell(0, seg_of(2, 1), 4, nv, ne); first += nv;
    n_tests++; if (first != exp_first) begin
      n_fail++; $display("FAIL dp_toggle_restart: got %0d pulses want %0d", first, exp_first);
    end
    dwell(0, seg_of(2, 1), 4, nv, ne);
    n_tests++; if (first + nv != 1 || value !== 16'h3212) begin
      n_fail++; $display("FAIL dp_toggle_word: got %0d pulses value=%h want 1 3212", first + nv, value);
    end
    n_tests++; if (dp_out !== exp_dp2) begin n_fail++; $display("FAIL dp_out_digit0: got %b want %b", dp_out, exp_dp2); end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [7:0] s;
    logic       c;
    int len, cnum;
    cnum = 0;
    repeat (250) begin
      if ($urandom_range(0, 99) < 10) a = 4'($urandom);
      else a = an_of(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) s = 8'($urandom);
      else s = seg_of(int'($urandom_range(0, 15)), 1'($urandom));
      len = int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) begin
        c = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 9) == 0) s[0] = ~s[0];
        cyc(a, s, c);
        cnum++;
        n_tests++; if (valid !== m_valid) begin
          n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", cnum, valid, m_valid);
        end
        n_tests++; if (err !== m_err) begin
          n_fail++; $display("FAIL rand_err cyc %0d: got %b want %b", cnum, err, m_err);
        end
        n_tests++; if (value !== m_value) begin
          n_fail++; $display("FAIL rand_value cyc %0d: got %h want %h", cnum, value, m_value);
        end
        n_tests++; if (dp_out !== m_dp) begin
          n_fail++; $display("FAIL rand_dp cyc %0d: got %b want %b", cnum, dp_out, m_dp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_short_dwell();
    test_bad_code();
    test_glitch();
    test_clear();
    test_reset_mid();
    test_all_codes();
    test_dp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sev_seg_reader.md
# sev_seg_reader

Monitors a multiplexed, active-low seven-segment display bus (per-digit anode enables plus shared 8-bit segment lines) and reconstructs the hexadecimal value being displayed. It sits beside the display driver path as a readback/self-check block. It debounces each digit dwell, maps the segment pattern back to a 4-bit nibble, and publishes a complete multi-digit word with a one-cycle valid strobe.

## Interface
- DIGITS, 4: number of multiplexed digits; the value width is 4*DIGITS.
- STABLE_CYCLES, 8: consecutive identical samples required before a dwell is captured; legal range is 2..255.
- clk  input  1  sole clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- an_n  input  DIGITS  anode enables, active-low; exactly one low selects a digit.
- sev_seg_leds  input  8  segment lines, active-low, ordered {g,f,e,d,c,b,a,dp}.
- clear  input  1  synchronous; discards a partially collected word.
- value  output  4*DIGITS  last complete word; digit i is in value[4i+3:4i].
- dp_out  output  DIGITS  captured decimal-point state per digit, 1 = lit.
- valid  output  1  one-cycle pulse when value is updated with a complete word.
- err  output  1  one-cycle pulse when a stable pattern matches no hex code.

## Operation
- Inputs are synchronous to clk. The block has no synchronizers.
- Code map for sev_seg_leds[7:1], hex 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- State IDLE: an_n is not one-hot-low (all high or more than one low). The stability counter holds 0.
- IDLE -> TRACK: when a one-hot sample arrives, the counter loads 1 and the sample {an_n, sev_seg_leds} is registered.
- TRACK:
  - If the sample equals the registered one, the counter increments.
  - If the sample differs and is one-hot, the counter reloads 1 with the new sample.
  - If the sample is not one-hot, the block goes to IDLE.
- TRACK -> CAPTURED: on the edge that registers the STABLE_CYCLES-th identical sample, the pattern is decoded.
  - Hit: the nibble is written to that digit's slot and its seen bit is set.
  - Miss: err pulses, and neither the slot nor the seen bit changes.
- CAPTURED: holds while the sample is unchanged, with no further captures. Any change leaves CAPTURED by the same rules as TRACK.
- Word complete: when the seen bits become all ones, the complete word is copied to value on the same edge as the final slot write. valid pulses that cycle and seen clears.
- Re-capture of an already-seen digit before the word completes overwrites its slot.
- clear: clears seen and returns to IDLE. Collected slots are discarded and value is held. If clear coincides with a capture, clear wins: no write, no valid, no err.

## Timing
- Reset values: value = 0, dp_out = 0, valid = 0, err = 0, seen = 0, state IDLE, counter 0.
- Sample held from edge 1 -> capture at edge STABLE_CYCLES. valid and err are visible after that edge.
- valid and err are never asserted together and never for two consecutive cycles from one dwell.
- Reset asserted mid-dwell or mid-word immediately returns every register to its reset value.

## Configuration
- SEV_SEG_READER_DP_EN defined: sev_seg_leds[0] is part of the stability comparison. Its inverse is stored per digit and published in dp_out together with value.
- Macro undefined: bit 0 is ignored everywhere, dp toggles do not restart the dwell, and dp_out is tied to 0.

## Structure
- Shared package sev_seg_pkg holds:
  - the sixteen 7-bit segment code constants;
  - the default DIGITS and STABLE_CYCLES;
  - the state enum (IDLE, TRACK, CAPTURED).
- Sub-module sev_seg_encoder: combinational {g..a} -> nibble plus a hit flag. It is instantiated once.

## Test plan
- Basic word: DIGITS=4, STABLE_CYCLES=8. Drive digit 0..3 with the codes for 1, 2, 3, 4 for 8 cycles each -> value = 16'h4321 and one valid pulse after the 32nd edge.
- Short dwell: hold digit 2 for 7 cycles, then a different digit -> no capture, seen[2] stays 0, no valid.
- Bad code: digit 1 stable at 1010101 for 8 cycles -> err pulses once, valid absent, value unchanged.
- Glitches: two anodes low for 3 cycles in the middle of a dwell -> the counter restarts. The capture occurs 8 cycles after the one-hot sample resumes.
- Clear and reset: assert clear on the capture edge of the last digit -> no valid, value keeps the previous word. Assert rst_n low mid-word -> all outputs 0.
- DP (with SEV_SEG_READER_DP_EN): digit 3 shows 8 with dp lit (00000000) -> dp_out[3] = 1 and value[15:12] = 8. With the macro undefined, dp_out = 0.
